// File: rtl/alu_rs.sv
// alu_rs: reservation station holding ALU micro-ops until operands and flags arrive.
// Define ALU_RS_ISSUE_BYPASS_EN to let a fully ready op issue in its insert cycle.
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 5
`endif

package alu_rs_pkg;

    typedef enum logic [3:0] {
        ALU_PLUS,
        ALU_MINUS,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_LSL,
        ALU_LSR,
        ALU_ASR,
        ALU_MOV
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    typedef struct packed {
        alu_op_t                  op;
        logic [`GPR_SIZE-1:0]     val_a;
        logic                     rdy_a;
        logic [`ROB_IDX_SIZE-1:0] tag_a;
        logic [`GPR_SIZE-1:0]     val_b;
        logic                     rdy_b;
        logic [`ROB_IDX_SIZE-1:0] tag_b;
        nzcv_t                    nzcv;
        logic                     rdy_f;
        logic [`ROB_IDX_SIZE-1:0] tag_f;
        logic [`ROB_IDX_SIZE-1:0] dst;
        logic                     set_nzcv;
    } rs_entry_t;

endpackage

module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int NUM_ENTRIES = 4
) (
    input  logic                          in_clk,
    input  logic                          in_rst,
    input  logic                          in_flush,
    input  logic                          in_insert,
    input  alu_op_t                       in_op,
    input  logic [`GPR_SIZE-1:0]          in_val_a,
    input  logic [`GPR_SIZE-1:0]          in_val_b,
    input  logic                          in_ready_a,
    input  logic                          in_ready_b,
    input  logic [`ROB_IDX_SIZE-1:0]      in_tag_a,
    input  logic [`ROB_IDX_SIZE-1:0]      in_tag_b,
    input  nzcv_t                         in_nzcv,
    input  logic                          in_nzcv_ready,
    input  logic [`ROB_IDX_SIZE-1:0]      in_nzcv_tag,
    input  logic [`ROB_IDX_SIZE-1:0]      in_dst_rob_index,
    input  logic                          in_set_nzcv,
    input  logic                          in_fu_done,
    input  logic [`ROB_IDX_SIZE-1:0]      in_fu_dst_rob_index,
    input  logic [`GPR_SIZE-1:0]          in_fu_value,
    input  logic                          in_fu_set_nzcv,
    input  nzcv_t                         in_fu_nzcv,
    input  logic                          in_alu_ready,
    output logic                          out_full,
    output logic [$clog2(NUM_ENTRIES):0]  out_count,
    output logic                          out_alu_start,
    output alu_op_t                       out_alu_op,
    output logic [`GPR_SIZE-1:0]          out_alu_val_a,
    output logic [`GPR_SIZE-1:0]          out_alu_val_b,
    output logic [`ROB_IDX_SIZE-1:0]      out_alu_dst_rob_index,
    output logic                          out_alu_set_nzcv,
    output nzcv_t                         out_alu_nzcv
);

    localparam int IW = $clog2(NUM_ENTRIES);
    localparam int CW = IW + 1;

    logic [NUM_ENTRIES-1:0] valid_q;
    logic [NUM_ENTRIES-1:0] valid_d;
    rs_entry_t              ent_q [NUM_ENTRIES];
    rs_entry_t              ent_d [NUM_ENTRIES];
    logic [CW-1:0]          count_q;

    rs_entry_t              new_ent;
    logic                   new_ready;
    logic [IW-1:0]          free_idx;
    logic [IW-1:0]          sel_idx;
    logic                   sel_found;
    logic                   full;
    logic                   issue;
    logic                   bypass;
    logic                   ins_en;

    // Incoming op sees the same-cycle broadcast so its producer is never missed
    always_comb begin
        new_ent = '0;
        new_ent.op = in_op;
        new_ent.tag_a = in_tag_a;
        new_ent.tag_b = in_tag_b;
        new_ent.tag_f = in_nzcv_tag;
        new_ent.dst = in_dst_rob_index;
        new_ent.set_nzcv = in_set_nzcv;
        new_ent.rdy_a = in_ready_a
            | (in_fu_done & (in_tag_a == in_fu_dst_rob_index));
        new_ent.val_a = in_ready_a ? in_val_a : in_fu_value;
        new_ent.rdy_b = in_ready_b
            | (in_fu_done & (in_tag_b == in_fu_dst_rob_index));
        new_ent.val_b = in_ready_b ? in_val_b : in_fu_value;
        new_ent.rdy_f = in_nzcv_ready
            | (in_fu_done & in_fu_set_nzcv
               & (in_nzcv_tag == in_fu_dst_rob_index));
        new_ent.nzcv = in_nzcv_ready ? in_nzcv : in_fu_nzcv;
        new_ready = new_ent.rdy_a & new_ent.rdy_b & new_ent.rdy_f;
    end

    // Descending scan leaves the lowest matching index in each result
    always_comb begin
        free_idx = '0;
        sel_idx = '0;
        sel_found = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = IW'(i);
            end
            if (valid_q[i] && ent_q[i].rdy_a && ent_q[i].rdy_b
                && ent_q[i].rdy_f) begin
                sel_idx = IW'(i);
                sel_found = 1'b1;
            end
        end
    end

    assign full = &valid_q;
    assign issue = in_alu_ready & sel_found;

`ifdef ALU_RS_ISSUE_BYPASS_EN
    assign bypass = in_insert & ~full & in_alu_ready
                    & ~sel_found & new_ready;
`else
    assign bypass = 1'b0;
`endif

    assign ins_en = in_insert & ~full & ~bypass;

    always_comb begin
        valid_d = valid_q;
        if (issue) begin
            valid_d[sel_idx] = 1'b0;
        end
        if (ins_en) begin
            valid_d[free_idx] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ent_d[i] = ent_q[i];
            if (ins_en && (free_idx == IW'(i))) begin
                ent_d[i] = new_ent;
            end else if (valid_q[i] && in_fu_done) begin
                if (!ent_q[i].rdy_a
                    && ent_q[i].tag_a == in_fu_dst_rob_index) begin
                    ent_d[i].rdy_a = 1'b1;
                    ent_d[i].val_a = in_fu_value;
                end
                if (!ent_q[i].rdy_b
                    && ent_q[i].tag_b == in_fu_dst_rob_index) begin
                    ent_d[i].rdy_b = 1'b1;
                    ent_d[i].val_b = in_fu_value;
                end
                if (!ent_q[i].rdy_f && in_fu_set_nzcv
                    && ent_q[i].tag_f == in_fu_dst_rob_index) begin
                    ent_d[i].rdy_f = 1'b1;
                    ent_d[i].nzcv = in_fu_nzcv;
                end
            end
        end
    end

    // Payload needs no reset; only valid bits define occupancy
    always_ff @(posedge in_clk) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ent_q[i] <= ent_d[i];
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            valid_q <= '0;
            count_q <= '0;
            out_alu_start <= 1'b0;
            out_alu_op <= ALU_PLUS;
            out_alu_val_a <= '0;
            out_alu_val_b <= '0;
            out_alu_dst_rob_index <= '0;
            out_alu_set_nzcv <= 1'b0;
            out_alu_nzcv <= '0;
        end else if (in_flush) begin
            valid_q <= '0;
            count_q <= '0;
            out_alu_start <= 1'b0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_q + CW'(ins_en) - CW'(issue);
            out_alu_start <= issue | bypass;
            if (issue) begin
                out_alu_op <= ent_q[sel_idx].op;
                out_alu_val_a <= ent_q[sel_idx].val_a;
                out_alu_val_b <= ent_q[sel_idx].val_b;
                out_alu_dst_rob_index <= ent_q[sel_idx].dst;
                out_alu_set_nzcv <= ent_q[sel_idx].set_nzcv;
                out_alu_nzcv <= ent_q[sel_idx].nzcv;
            end else if (bypass) begin
                out_alu_op <= new_ent.op;
                out_alu_val_a <= new_ent.val_a;
                out_alu_val_b <= new_ent.val_b;
                out_alu_dst_rob_index <= new_ent.dst;
                out_alu_set_nzcv <= new_ent.set_nzcv;
                out_alu_nzcv <= new_ent.nzcv;
            end
        end
    end

    assign out_full = full;
    assign out_count = count_q;

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station feeding the ALU functional unit.
- Holds dispatched ALU micro-ops until both source operands and input NZCV are available.
- Snoops the functional-unit completion broadcast (the same done/rob-index/value/nzcv bus delivered to the ROB) to wake waiting operands.
- Issues one ready op per cycle to the ALU start/op/val_a/val_b/dst-index/set_nzcv/nzcv inputs.

Parameters:
- NUM_ENTRIES, 4, number of station slots; power of two, 2..16.
- Widths come from the codebase macros GPR_SIZE (64) and ROB_IDX_SIZE, and the types alu_op_t and nzcv_t.

Ports:
- in_clk  input  1  clock, rising edge.
- in_rst  input  1  reset; asynchronous, active-high.
- in_flush  input  1  synchronous squash of all entries (mispredict).
- in_insert  input  1  dispatch writes a new op this cycle.
- in_op  input  alu_op_t  ALU operation.
- in_val_a / in_val_b  input  GPR_SIZE  operand value when ready.
- in_ready_a / in_ready_b  input  1  operand already valid.
- in_tag_a / in_tag_b  input  ROB_IDX_SIZE  producer ROB index when not ready.
- in_nzcv  input  nzcv_t  input flags when ready.
- in_nzcv_ready  input  1  flags already valid.
- in_nzcv_tag  input  ROB_IDX_SIZE  producer of flags.
- in_dst_rob_index  input  ROB_IDX_SIZE  destination ROB slot.
- in_set_nzcv  input  1  op writes flags.
- in_fu_done  input  1  completion broadcast valid.
- in_fu_dst_rob_index  input  ROB_IDX_SIZE  completing ROB slot.
- in_fu_value  input  GPR_SIZE  completion value.
- in_fu_set_nzcv  input  1  completion carries flags.
- in_fu_nzcv  input  nzcv_t  completion flags.
- in_alu_ready  input  1  ALU can accept an op.
- out_full  output  1  all slots valid; dispatch must not insert.
- out_count  output  $clog2(NUM_ENTRIES)+1  valid-slot count.
- out_alu_start, out_alu_op, out_alu_val_a, out_alu_val_b, out_alu_dst_rob_index, out_alu_set_nzcv, out_alu_nzcv  output  as ALU inputs  registered issue bundle.

Behaviour:
- Reset (async, in_rst=1): all valid bits 0; out_full=0; out_count=0; out_alu_start=0; every other out_alu_* = 0.
- Per entry: valid, op, val_a/rdy_a/tag_a, val_b/rdy_b/tag_b, nzcv/rdy_f/tag_f, dst, set_nzcv.
- Insert: when in_insert && !out_full, write the lowest-index invalid slot.
  - out_full is computed from registered state, so an insert while full is dropped even if an issue frees a slot the same cycle.
  - Insert while full: state unchanged.
- Wake-up: when in_fu_done, every valid not-ready operand with tag == in_fu_dst_rob_index captures in_fu_value and sets ready. Flags wake only when in_fu_set_nzcv is also 1.
  - The same match applies to the op being inserted that cycle, so a producer completing in the insert cycle is never lost.
- Select: an entry is eligible when valid && rdy_a && rdy_b && rdy_f, evaluated on registered state. Choose the lowest-index eligible entry.
- Issue: if in_alu_ready and an eligible entry exists, invalidate it at the clock edge and load the out_alu_* bundle.
  - out_alu_start=1 for exactly one cycle per issued op; otherwise out_alu_start=0 and the data outputs hold.
  - Latency: operand woken in cycle t → earliest out_alu_start at t+2 (capture edge, then issue edge). Insert fully ready at t → out_alu_start at t+2.
- in_alu_ready=0: nothing leaves; entries keep waiting.
- Flush: synchronous; at the edge all valid bits clear and out_alu_start=0. It overrides a simultaneous insert, wake-up and issue.
- out_count: registered; updated +1 on insert, −1 on issue; net 0 when both occur.

Optional Feature:
- ALU_RS_ISSUE_BYPASS_EN defined: an op inserted with all three sources ready, or made ready by a same-cycle broadcast, may issue in its insert cycle when no stored entry is eligible.
  - It is never written to a slot.
  - Insert-to-out_alu_start latency drops to 1 cycle.
  - Stored eligible entries keep priority over the bypassed op.
- Not defined: every op occupies a slot for at least one cycle.

Test Plan:
- Reset mid-operation: 3 entries valid, assert in_rst asynchronously → out_count=0, out_alu_start=0, out_full=0 immediately.
- Ready insert: in_insert with PLUS, a=5, b=7, all ready, dst=2, in_alu_ready=1 → two edges later out_alu_start=1, val_a=5, val_b=7, dst=2 for one cycle; out_count back to 0.
- Wake-up: insert with b waiting on tag 3 → held. Broadcast done, rob=3, value=0x10 → next cycle captured, following cycle out_alu_val_b=0x10. Broadcast with tag 4 → no issue.
- Same-cycle capture: insert waiting on tag 1 while in_fu_done, rob=1, value=9 → the op issues with operand 9 and never stalls.
- Full/insert drop: NUM_ENTRIES=4, fill 4 non-ready ops → out_full=1. A 5th insert concurrent with one issue → dropped; out_count=3 afterwards.
- Flush priority: 2 ready entries, in_alu_ready=0, then in_flush with in_insert=1 → next cycle out_count=0, no start pulse; in_alu_ready later → out_alu_start stays 0.
